// File: rtl/io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : io_input_conditioner
// Purpose  : Front-end for the core io_input_bus. Every raw KEY/SW pin goes
//            through a 2-flop synchronizer and a per-bit debounce filter.
//            The result is clean levels in the layout {KEY, SW}, with
//            pressed=1. The block also produces one-cycle press and change
//            pulses.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock           in   system clock, rising edge
//   reset           in   synchronous active-high reset
//   key_raw         in   [KEY_WIDTH]  asynchronous push-button pins
//   sw_raw          in   [SW_WIDTH]   asynchronous slide-switch pins
//   io_input_bus    out  [KEY_WIDTH+SW_WIDTH] debounced {KEY, SW}, pressed=1
//   key_press_pulse out  [KEY_WIDTH]  one-cycle pulse per debounced press
//   input_changed   out  one-cycle pulse when any debounced bit changes
// Optional feature
//   IO_KEY_REPEAT_EN : when defined, a held key re-fires key_press_pulse
//                      every REPEAT_CYCLES cycles.
// ============================================================================
module io_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int KEY_WIDTH       = 4,
  parameter int SW_WIDTH        = 10,
  parameter int KEY_ACTIVE_LOW  = 1,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [KEY_WIDTH-1:0]          key_raw,
  input  logic [SW_WIDTH-1:0]           sw_raw,
  output logic [KEY_WIDTH+SW_WIDTH-1:0] io_input_bus,
  output logic [KEY_WIDTH-1:0]          key_press_pulse,
  output logic                          input_changed
);

  localparam int NBITS = KEY_WIDTH + SW_WIDTH;
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic KEY_IDLE = (KEY_ACTIVE_LOW != 0);
  // Inactive raw level of every pin. It is also the XOR mask that turns
  // active-low keys into pressed=1.
  localparam logic [NBITS-1:0] RAW_IDLE = {{KEY_WIDTH{KEY_IDLE}}, {SW_WIDTH{1'b0}}};

  logic [NBITS-1:0]     sync1_q, sync2_q;
  logic [NBITS-1:0]     deb_q, deb_d;
  logic [CNT_W-1:0]     cnt_q [NBITS];
  logic [CNT_W-1:0]     cnt_d [NBITS];
  logic [KEY_WIDTH-1:0] pulse_q, pulse_d;
  logic                 changed_q, changed_d;

  logic [NBITS-1:0]     w_norm;
  logic [KEY_WIDTH-1:0] w_key_rise;

  // --------------------------------------------------------------------------
  // Synchronizer. It resets to the idle pin level, so that a key that is not
  // pressed never looks like a press coming out of reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= {key_raw, sw_raw};
      sync2_q <= sync1_q;
    end
  end

  assign w_norm = sync2_q ^ RAW_IDLE;

  // --------------------------------------------------------------------------
  // Per-bit debounce. Any agreement clears the count, so a glitch that
  // reverses mid-count carries no partial credit into the next attempt.
  // --------------------------------------------------------------------------
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NBITS; i++) begin
      cnt_d[i] = '0;
      if (w_norm[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = w_norm[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_key_rise = deb_d[NBITS-1:SW_WIDTH] & ~deb_q[NBITS-1:SW_WIDTH];
  assign changed_d  = |(deb_d ^ deb_q);

`ifdef IO_KEY_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0]     rep_q [KEY_WIDTH];
  logic [REP_W-1:0]     rep_d [KEY_WIDTH];
  logic [KEY_WIDTH-1:0] w_rep_fire;

  // A repeat counter runs only while the key was 1 and stays 1. This clears
  // it on the press cycle and on release, and suppresses the repeat in the
  // same cycle that the key falls.
  always_comb begin
    for (int i = 0; i < KEY_WIDTH; i++) begin
      rep_d[i]      = '0;
      w_rep_fire[i] = 1'b0;
      if (deb_q[SW_WIDTH+i] && deb_d[SW_WIDTH+i]) begin
        if (rep_q[i] == REP_MAX) begin
          w_rep_fire[i] = 1'b1;
        end else begin
          rep_d[i] = rep_q[i] + REP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < KEY_WIDTH; i++) begin
      if (reset) rep_q[i] <= '0;
      else       rep_q[i] <= rep_d[i];
    end
  end

  assign pulse_d = w_key_rise | w_rep_fire;
`else
  // Without auto-repeat, REPEAT_CYCLES has no effect. It is tied off here so
  // that it is visibly consumed.
  logic w_unused_repeat;
  assign w_unused_repeat = REPEAT_CYCLES[0];
  assign pulse_d         = w_key_rise;
`endif

  // --------------------------------------------------------------------------
  // State and output registers. The pulses are registered on the same edge
  // as deb_q. As a result, each pulse is high in exactly the cycle in which
  // the new debounced level first appears on io_input_bus.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q     <= '0;
      pulse_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      deb_q     <= deb_d;
      pulse_q   <= pulse_d;
      changed_q <= changed_d;
    end
    for (int i = 0; i < NBITS; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  assign io_input_bus    = deb_q;
  assign key_press_pulse = pulse_q;
  assign input_changed   = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_io_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_input_conditioner
// Purpose  : Scoreboard bench for io_input_conditioner with DEBOUNCE_CYCLES=4.
//            The stimulus pushes the expected output events (cycle, bus,
//            press pulse, change pulse). A monitor pops and compares an event
//            whenever the DUT pulses. Between events it also checks that the
//            bus holds steady.
//            Define IO_KEY_REPEAT_EN to add the auto-repeat scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_input_conditioner;

  localparam int LAT = 6;  // raw change to bus update, DEBOUNCE_CYCLES + 2

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  key_raw;
  logic [9:0]  sw_raw;
  logic [13:0] io_input_bus;
  logic [3:0]  key_press_pulse;
  logic        input_changed;

  io_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .KEY_WIDTH(4),
    .SW_WIDTH(10),
    .KEY_ACTIVE_LOW(1),
    .REPEAT_CYCLES(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_raw(key_raw),
    .sw_raw(sw_raw),
    .io_input_bus(io_input_bus),
    .key_press_pulse(key_press_pulse),
    .input_changed(input_changed)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [13:0] bus;
    logic [3:0]  kp;
    logic        ch;
  } ev_t;

  ev_t         exp_q[$];
  int          cyc = 0;
  bit          rst_seen = 1'b0;
  bit          started = 1'b0;
  logic [13:0] exp_bus = '0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
    if (reset) started <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push(input int c, input logic [13:0] b, input logic [3:0] k, input logic ch);
    ev_t e;
    e.cyc = c; e.bus = b; e.kp = k; e.ch = ch;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clock) begin
    ev_t e;
    if (started) begin
      if (rst_seen) begin
        chk("rst_bus", 32'(io_input_bus), 32'h0);
        chk("rst_key_pulse", 32'(key_press_pulse), 32'h0);
        chk("rst_changed", 32'(input_changed), 32'h0);
        exp_bus = '0;
      end else if (input_changed || key_press_pulse != 4'h0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {27'h0, key_press_pulse, input_changed}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          chk("event_bus", 32'(io_input_bus), 32'(e.bus));
          chk("event_key_pulse", 32'(key_press_pulse), 32'(e.kp));
          chk("event_changed", 32'(input_changed), 32'(e.ch));
          exp_bus = e.bus;
        end
      end else begin
        chk("bus_hold", 32'(io_input_bus), 32'(exp_bus));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with all switches on and no keys pressed
    reset   = 1'b1;
    key_raw = 4'hF;
    sw_raw  = 10'h3FF;
    step(2);
    reset = 1'b0;
    push(cyc + LAT, 14'h03FF, 4'h0, 1'b1);
    step(12);

    // 2. Switch transitions
    sw_raw = 10'h000;
    push(cyc + LAT, 14'h0000, 4'h0, 1'b1);
    step(10);
    sw_raw[3] = 1'b1;
    push(cyc + LAT, 14'h0008, 4'h0, 1'b1);
    step(10);
    sw_raw[3] = 1'b0;
    push(cyc + LAT, 14'h0000, 4'h0, 1'b1);
    step(10);

    // 3. A 3-cycle glitch is rejected; exactly 4 cycles is accepted
    key_raw[0] = 1'b0;
    step(3);
    key_raw[0] = 1'b1;
    step(12);
    key_raw[0] = 1'b0;
    push(cyc + LAT, 14'h0400, 4'h1, 1'b1);
    step(4);
    key_raw[0] = 1'b1;
    push(cyc + LAT, 14'h0000, 4'h0, 1'b1);
    step(12);

    // 4. Press and hold, then release
    key_raw[1] = 1'b0;
    push(cyc + LAT, 14'h0800, 4'h2, 1'b1);
    step(20);
    key_raw[1] = 1'b1;
    push(cyc + LAT, 14'h0000, 4'h0, 1'b1);
    step(10);

    // 5. Reset in the middle of a debounce count
    key_raw[2] = 1'b0;
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    push(cyc + LAT, 14'h1000, 4'h4, 1'b1);
    step(14);
    key_raw[2] = 1'b1;
    push(cyc + LAT, 14'h0000, 4'h0, 1'b1);
    step(10);

    // Simultaneous key and switch change gives one merged event
    key_raw[0] = 1'b0;
    sw_raw[0]  = 1'b1;
    push(cyc + LAT, 14'h0401, 4'h1, 1'b1);
    step(10);
    key_raw[0] = 1'b1;
    sw_raw[0]  = 1'b0;
    push(cyc + LAT, 14'h0000, 4'h0, 1'b1);
    step(10);

`ifdef IO_KEY_REPEAT_EN
    // 6. Auto-repeat every 8 cycles while key 3 is held
    key_raw[3] = 1'b0;
    push(cyc + LAT, 14'h2000, 4'h8, 1'b1);
    for (int j = 1; j <= 4; j++) push(cyc + LAT + 8 * j, 14'h2000, 4'h8, 1'b0);
    step(40);
    key_raw[3] = 1'b1;
    push(cyc + LAT, 14'h0000, 4'h0, 1'b1);
    step(16);
`endif

    step(15);
    chk("events_pending", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
